spi_frame_decoder: RTL

Front-end SPI receiver that turns raw pad-level SPI Mode 0 traffic (SCLK, COPI, nCS) into one decoded transaction per frame. Each transaction is a single-cycle `valid` strobe with `read_write`, `addr` and `data`, which drives the register bank's write port. The block synchronizes the asynchronous pad signals into the `clk` domain, deserializes 16-bit frames, and rejects malformed frames.

---
 rtl/spi_pkg.sv | 24 ++
 rtl/spi_sync_edge.sv | 39 +++
 rtl/spi_frame_decoder.sv | 126 ++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// ============================================================================
// spi_pkg : frame geometry and FSM state type for the SPI frame decoder
// Rev 1.0
// ============================================================================
`default_nettype none

package spi_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int CNT_W      = 5;

  localparam logic [CNT_W-1:0] CNT_SAT  = 5'd17;
  localparam logic [CNT_W-1:0] CNT_FULL = 5'd16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_t;

endpackage : spi_pkg

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// ============================================================================
// spi_sync_edge : multi-flop synchronizer with history flop and edge outputs
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;

  // Chain and history reset low: a pad already low at reset release
  // never produces a falling edge, so an in-flight frame is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      hist <= sync[SYNC_STAGES-1];
    end
  end

  assign level = sync[SYNC_STAGES-1];
  assign rise  = level & ~hist;
  assign fall  = ~level & hist;

endmodule : spi_sync_edge

`default_nettype wire

// File: rtl/spi_frame_decoder.sv
// ============================================================================
// spi_frame_decoder : SPI mode-0 receiver, one decoded strobe per 16-bit frame
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_frame_decoder
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              copi,
  input  logic              ncs,
  output logic              valid,
  output logic              read_write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              frame_err,
  output logic              busy
);

  logic sclk_rise, sclk_fall_unused, sclk_level_unused;
  logic ncs_rise, ncs_fall, ncs_level_unused;
  logic copi_level, copi_rise_unused, copi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sclk),
    .level (sclk_level_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall_unused)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ncs),
    .level (ncs_level_unused),
    .rise  (ncs_rise),
    .fall  (ncs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (copi),
    .level (copi_level),
    .rise  (copi_rise_unused),
    .fall  (copi_fall_unused)
  );

  spi_state_t              state, state_nxt;
  logic [FRAME_BITS-1:0]   shreg;
  logic [CNT_W-1:0]        cnt;
  logic                    clear, shift_en, load_out, pulse_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ncs_fall) state_nxt = SHIFT;
      SHIFT:   if (ncs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The nCS rise takes priority, so a coincident SCLK rise is not counted.
  always_comb begin
    clear     = 1'b0;
    shift_en  = 1'b0;
    load_out  = 1'b0;
    pulse_err = 1'b0;
    case (state)
      IDLE: clear = ncs_fall;
      SHIFT: begin
        if (ncs_rise) begin
          load_out  = (cnt == CNT_FULL);
          pulse_err = (cnt != CNT_FULL);
        end else begin
          shift_en  = sclk_rise;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      cnt        <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      read_write <= 1'b0;
      addr       <= '0;
      data       <= '0;
    end else begin
      valid     <= load_out;
      frame_err <= pulse_err;
      if (clear) begin
        shreg <= '0;
        cnt   <= '0;
      end else if (shift_en) begin
        shreg <= {shreg[FRAME_BITS-2:0], copi_level};
        if (cnt != CNT_SAT) cnt <= cnt + 5'd1;
      end
      if (load_out) begin
        read_write <= shreg[FRAME_BITS-1];
        addr       <= shreg[FRAME_BITS-2:DATA_W];
        data       <= shreg[DATA_W-1:0];
      end
    end
  end

  assign busy = (state == SHIFT);

endmodule : spi_frame_decoder

`default_nettype wire
